// File: rtl/ahb_bus_arbiter_if.sv
// ahb_bus_arbiter_if
//   Groups the request/grant signals exchanged between the AHB masters and the arbiter.
//   The master modport is the requesting side. The slave modport is the arbiter side.
//   hbusreq/hlock    : per-master bus request and locked-access request
//   htrans/hburst    : transfer type and burst type of the current address-phase owner
//   hready           : transfer-done from the slave mux
//   hgrant           : one-hot grant
//   hmaster          : address-phase owner index
//   hmaster_data     : data-phase owner index
//   hmastlock        : current address-phase transfer is locked
interface ahb_bus_arbiter_if #(
   parameter int NUM_MASTERS = 4,
   parameter int MW          = 2
);
   logic [NUM_MASTERS-1:0] hbusreq;
   logic [NUM_MASTERS-1:0] hlock;
   logic [1:0]             htrans;
   logic [2:0]             hburst;
   logic                   hready;
   logic [NUM_MASTERS-1:0] hgrant;
   logic [MW-1:0]          hmaster;
   logic [MW-1:0]          hmaster_data;
   logic                   hmastlock;

   modport master (
      output hbusreq, hlock, htrans, hburst, hready,
      input  hgrant, hmaster, hmaster_data, hmastlock
   );

   modport slave (
      input  hbusreq, hlock, htrans, hburst, hready,
      output hgrant, hmaster, hmaster_data, hmastlock
   );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter
//   Round-robin AHB arbiter for NUM_MASTERS masters. Ownership changes only on accepted
//   transfer boundaries. Fixed-length bursts and locked sequences are never split.
//   hclk   : bus clock, rising edge
//   hreset : asynchronous active-high reset
//   bus    : ahb_bus_arbiter_if.slave carrying requests, transfer info, grant and owner outputs
module ahb_bus_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int MW          = 2
) (
   input  logic             hclk,
   input  logic             hreset,
   ahb_bus_arbiter_if.slave bus
);

   typedef enum logic {ST_ARB = 1'b0, ST_LOCKED = 1'b1} state_t;

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_BUSY   = 2'b01;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   localparam logic [NUM_MASTERS-1:0] GRANT_M0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
   logic [MW-1:0]          hmaster_q, hmaster_d;
   logic [MW-1:0]          hmaster_data_q, hmaster_data_d;
   logic                   hmastlock_q, hmastlock_d;
   logic [3:0]             remain_q, remain_d;
   logic [MW-1:0]          rr_ptr_q, rr_ptr_d;

   logic [3:0]             next_remain;
   logic [MW-1:0]          owner_idx;
   logic                   lock_cond;
   logic                   rearb;
   logic                   found;
   logic [MW-1:0]          winner;

   // Beat count the current fixed burst will have after this edge.
   always_comb begin
      next_remain = remain_q;
      if (bus.hready) begin
         case (bus.htrans)
            TR_IDLE:   next_remain = 4'd0;
            TR_BUSY:   next_remain = remain_q;
            TR_NONSEQ: begin
               case (bus.hburst)
                  3'b000, 3'b001: next_remain = 4'd0;
                  3'b010, 3'b011: next_remain = 4'd3;
                  3'b100, 3'b101: next_remain = 4'd7;
                  3'b110, 3'b111: next_remain = 4'd15;
                  default:        next_remain = 4'd0;
               endcase
            end
            TR_SEQ:    next_remain = (remain_q != 4'd0) ? (remain_q - 4'd1) : 4'd0;
            default:   next_remain = 4'd0;
         endcase
      end else begin
         next_remain = remain_q;
      end
   end

   // Index of the current grant holder. The grant is one-hot, so the last match is the only match.
   always_comb begin
      owner_idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         owner_idx = hgrant_q[i] ? MW'(i) : owner_idx;
      end
   end

   // The owner keeps the bus while it requests with hlock. Otherwise re-arbitration waits for a burst boundary.
   always_comb begin
      lock_cond = bus.hlock[owner_idx] & bus.hbusreq[owner_idx];
      rearb     = bus.hready & (next_remain == 4'd0) & ~lock_cond;
   end

   // Round-robin scan starting just after rr_ptr and wrapping around, ending at rr_ptr itself.
   always_comb begin
      int            cand;
      logic [MW-1:0] cand_idx;
      found    = 1'b0;
      winner   = '0;
      cand     = 0;
      cand_idx = '0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         cand = int'(rr_ptr_q) + k;
         if (cand >= NUM_MASTERS) begin
            cand = cand - NUM_MASTERS;
         end else begin
            cand = cand;
         end
         cand_idx = MW'(cand);
         if (!found && bus.hbusreq[cand_idx]) begin
            found  = 1'b1;
            winner = cand_idx;
         end else begin
            found  = found;
         end
      end
   end

   // Next-state logic. Everything holds while hready is low.
   always_comb begin
      state_d        = state_q;
      hgrant_d       = hgrant_q;
      hmaster_d      = hmaster_q;
      hmaster_data_d = hmaster_data_q;
      hmastlock_d    = hmastlock_q;
      remain_d       = remain_q;
      rr_ptr_d       = rr_ptr_q;
      if (bus.hready) begin
         remain_d       = next_remain;
         hmaster_d      = owner_idx;
         hmastlock_d    = bus.hlock[owner_idx];
         hmaster_data_d = hmaster_q;
         case (state_q)
            ST_ARB:    state_d = lock_cond ? ST_LOCKED : ST_ARB;
            ST_LOCKED: state_d = lock_cond ? ST_LOCKED : ST_ARB;
            default:   state_d = ST_ARB;
         endcase
         if (rearb) begin
            if (found) begin
               hgrant_d = GRANT_M0 << winner;
               rr_ptr_d = winner;
            end else begin
               // With no requester, master 0 gets a default grant. rr_ptr is left unchanged.
               hgrant_d = GRANT_M0;
               rr_ptr_d = rr_ptr_q;
            end
         end else begin
            hgrant_d = hgrant_q;
         end
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers. A reset aborts any burst or lock in progress.
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q        <= ST_ARB;
         hgrant_q       <= GRANT_M0;
         hmaster_q      <= '0;
         hmaster_data_q <= '0;
         hmastlock_q    <= 1'b0;
         remain_q       <= 4'd0;
         rr_ptr_q       <= '0;
      end else begin
         state_q        <= state_d;
         hgrant_q       <= hgrant_d;
         hmaster_q      <= hmaster_d;
         hmaster_data_q <= hmaster_data_d;
         hmastlock_q    <= hmastlock_d;
         remain_q       <= remain_d;
         rr_ptr_q       <= rr_ptr_d;
      end
   end

   assign bus.hgrant       = hgrant_q;
   assign bus.hmaster      = hmaster_q;
   assign bus.hmaster_data = hmaster_data_q;
   assign bus.hmastlock    = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter
//   Randomized and directed stimulus for ahb_bus_arbiter. It is checked against a behavioural
//   model that tracks owner, pointer and beat count as plain integers.
module tb_ahb_bus_arbiter;

   localparam int N  = 4;
   localparam int MW = 2;

   logic hclk;
   logic hreset;

   int n_vec;
   int n_err;

   // Reference model state
   int m_owner;
   int m_rr;
   int m_rem;
   int m_hm;
   int m_hmd;
   int m_hml;

   ahb_bus_arbiter_if #(.NUM_MASTERS(N), .MW(MW)) bus_if ();

   ahb_bus_arbiter #(.NUM_MASTERS(N), .MW(MW)) dut (
      .hclk   (hclk),
      .hreset (hreset),
      .bus    (bus_if.slave)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = 0; m_rr = 0; m_rem = 0; m_hm = 0; m_hmd = 0; m_hml = 0;
   endtask

   // One accepted-or-waited edge of the model, using the inputs applied for that edge.
   task automatic model_edge(input logic [N-1:0] req, input logic [N-1:0] lck,
                             input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
      int nr;
      int win;
      int c;
      bit locked;
      if (rdy) begin
         case (tr)
            2'd0:    nr = 0;
            2'd1:    nr = m_rem;
            2'd2:    nr = (bu < 3'd2) ? 0 : (2 ** (int'(bu >> 1) + 1)) - 1;
            default: nr = (m_rem > 0) ? m_rem - 1 : 0;
         endcase
         locked = lck[m_owner] && req[m_owner];
         m_hmd  = m_hm;
         m_hm   = m_owner;
         m_hml  = lck[m_owner] ? 1 : 0;
         if (nr == 0 && !locked) begin
            win = -1;
            for (int k = 1; k <= N; k++) begin
               c = (m_rr + k) % N;
               if (win < 0 && req[c]) win = c;
            end
            if (win >= 0) begin
               m_owner = win;
               m_rr    = win;
            end else begin
               m_owner = 0;
            end
         end
         m_rem = nr;
      end
   endtask

   task automatic check_all(input string ctx);
      chk({ctx, ".hgrant"},       32'(bus_if.hgrant),       32'(1 << m_owner));
      chk({ctx, ".hmaster"},      32'(bus_if.hmaster),      32'(m_hm));
      chk({ctx, ".hmaster_data"}, 32'(bus_if.hmaster_data), 32'(m_hmd));
      chk({ctx, ".hmastlock"},    32'(bus_if.hmastlock),    32'(m_hml));
   endtask

   // Applies inputs just after an edge, advances one clock and compares 1 time unit after the edge.
   task automatic step(input logic [N-1:0] req, input logic [N-1:0] lck,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy, input string ctx);
      bus_if.hbusreq = req;
      bus_if.hlock   = lck;
      bus_if.htrans  = tr;
      bus_if.hburst  = bu;
      bus_if.hready  = rdy;
      model_edge(req, lck, tr, bu, rdy);
      @(posedge hclk);
      #1;
      check_all(ctx);
   endtask

   // Asserts reset in the middle of a cycle and holds it for two edges with random requests.
   task automatic apply_reset();
      bus_if.hbusreq = 4'($urandom);
      #2;
      hreset = 1'b1;
      #1;
      model_reset();
      check_all("rst_async");
      for (int i = 0; i < 2; i++) begin
         bus_if.hbusreq = 4'($urandom);
         @(posedge hclk);
         #1;
         check_all("rst_hold");
      end
      hreset = 1'b0;
   endtask

   initial begin
      logic [3:0] rr_exp [5];
      logic [3:0] rq;
      logic [3:0] lk;
      n_vec = 0;
      n_err = 0;
      hreset = 1'b1;
      bus_if.hbusreq = 4'b0000;
      bus_if.hlock   = 4'b0000;
      bus_if.htrans  = 2'b00;
      bus_if.hburst  = 3'b000;
      bus_if.hready  = 1'b1;
      model_reset();
      repeat (2) @(posedge hclk);
      #1;
      hreset = 1'b0;
      check_all("reset");

      // Round-robin rotation with all masters requesting single transfers
      rr_exp[0] = 4'b0010; rr_exp[1] = 4'b0100; rr_exp[2] = 4'b1000;
      rr_exp[3] = 4'b0001; rr_exp[4] = 4'b0010;
      for (int i = 0; i < 5; i++) begin
         step(4'b1111, 4'b0000, 2'b10, 3'b000, 1'b1, "rr");
         chk("rr_seq", 32'(bus_if.hgrant), 32'(rr_exp[i]));
      end

      apply_reset();

      // INCR4 protection: master 1 bursts while master 2 requests
      step(4'b0010, 4'b0000, 2'b10, 3'b000, 1'b1, "incr4_get");
      chk("incr4_own", 32'(bus_if.hgrant), 32'd2);
      step(4'b0110, 4'b0000, 2'b10, 3'b011, 1'b1, "incr4_b1");
      chk("incr4_hold1", 32'(bus_if.hgrant), 32'd2);
      step(4'b0110, 4'b0000, 2'b11, 3'b011, 1'b1, "incr4_b2");
      step(4'b0110, 4'b0000, 2'b11, 3'b011, 1'b1, "incr4_b3");
      chk("incr4_hold3", 32'(bus_if.hgrant), 32'd2);
      step(4'b0110, 4'b0000, 2'b11, 3'b011, 1'b1, "incr4_b4");
      chk("incr4_handover", 32'(bus_if.hgrant), 32'd4);

      // Wait states in the middle of an INCR8 by master 2
      step(4'b0100, 4'b0000, 2'b10, 3'b101, 1'b1, "ws_b1");
      step(4'b0100, 4'b0000, 2'b11, 3'b101, 1'b1, "ws_b2");
      for (int i = 0; i < 3; i++) begin
         step(4'($urandom), 4'b0000, 2'b11, 3'b101, 1'b0, "ws_wait");
         chk("ws_frozen", 32'(bus_if.hgrant), 32'd4);
      end
      for (int i = 0; i < 6; i++) begin
         step(4'b1001, 4'b0000, 2'b11, 3'b101, 1'b1, "ws_resume");
      end
      chk("ws_handover", 32'(bus_if.hgrant), 32'd8);

      // Locked sequence by master 3 while everyone requests
      step(4'b1111, 4'b1000, 2'b10, 3'b000, 1'b1, "lock_set");
      for (int i = 0; i < 6; i++) begin
         step(4'b1111, 4'b1000, 2'b10, 3'b000, 1'b1, "lock");
         chk("lock_grant", 32'(bus_if.hgrant), 32'd8);
         chk("lock_mastlock", 32'(bus_if.hmastlock), 32'd1);
      end
      step(4'b1111, 4'b0000, 2'b10, 3'b000, 1'b1, "unlock");
      chk("unlock_grant", 32'(bus_if.hgrant), 32'd1);

      // Idle bus parks on master 0 without moving the pointer
      step(4'b0100, 4'b0000, 2'b10, 3'b000, 1'b1, "idle_get");
      chk("idle_own2", 32'(bus_if.hgrant), 32'd4);
      step(4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1, "idle_park");
      chk("idle_default", 32'(bus_if.hgrant), 32'd1);
      step(4'b1111, 4'b0000, 2'b10, 3'b000, 1'b1, "idle_resume");
      chk("idle_next3", 32'(bus_if.hgrant), 32'd8);

      // Random traffic with occasional locks, wait states and resets
      for (int i = 0; i < 400; i++) begin
         rq = 4'($urandom);
         lk = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
         step(rq, lk, 2'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0), "rand");
         if (i % 100 == 99) apply_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
